// File: rtl/sevenseg_scan_decoder_if.sv
// Scanned 7-segment display bus: the driver's seg/digit lines plus the
// monitor's decoded status outputs.
interface sevenseg_scan_decoder_if;
    logic [6:0]  seg;
    logic [3:0]  digit;
    logic [15:0] digits;
    logic [3:0]  blank;
    logic        frame_valid;
    logic        err;
    logic        stale;

    // master = display driver side, slave = scan decoder
    modport master (
        output seg,
        output digit,
        input  digits,
        input  blank,
        input  frame_valid,
        input  err,
        input  stale
    );

    modport slave (
        input  seg,
        input  digit,
        output digits,
        output blank,
        output frame_valid,
        output err,
        output stale
    );
endinterface

// File: rtl/sevenseg_scan_decoder.sv
// Receiver for a multiplexed active-low 7-segment scan: waits for a stable
// dwell, decodes each position, and flags frames, bad patterns and staleness.
// Optional macro HEX_DECODE_EN adds the A-F glyphs to the decoder.
module sevenseg_scan_decoder #(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    reset,
    sevenseg_scan_decoder_if.slave  bus
);

    localparam int CW = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);
    localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [6:0]    SEG_OFF = 7'b1111111;

    logic [10:0]   sample_reg;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic          captured_reg, captured_next;
    logic [TW-1:0] to_cnt_reg, to_cnt_next;
    logic [3:0]    seen_reg, seen_next;
    logic          stale_reg, stale_next;
    logic          err_reg, err_next;
    logic          frame_valid_reg, frame_valid_next;
    logic [3:0]    digit_reg [4];
    logic [3:0]    blank_reg;

    logic [3:0] sel_low;
    logic       sel_valid;
    logic       same;
    logic       accept;
    logic [3:0] acc_pos;
    logic [6:0] acc_seg;
    logic [4:0] dec;
    logic       is_blank;
    logic       capture;
    logic       timeout_hit;
    logic [3:0] seen_set;

    // Returns {decodable, value} for an active-low {g..a} pattern.
    function automatic logic [4:0] decode(input logic [6:0] s);
        logic [4:0] r;
        case (s)
            7'b1000000: r = {1'b1, 4'h0};
            7'b1111001: r = {1'b1, 4'h1};
            7'b0100100: r = {1'b1, 4'h2};
            7'b0110000: r = {1'b1, 4'h3};
            7'b0011001: r = {1'b1, 4'h4};
            7'b0010010: r = {1'b1, 4'h5};
            7'b0000010: r = {1'b1, 4'h6};
            7'b1111000: r = {1'b1, 4'h7};
            7'b0000000: r = {1'b1, 4'h8};
            7'b0010000: r = {1'b1, 4'h9};
`ifdef HEX_DECODE_EN
            7'b0001000: r = {1'b1, 4'hA};
            7'b0000011: r = {1'b1, 4'hB};
            7'b1000110: r = {1'b1, 4'hC};
            7'b0100001: r = {1'b1, 4'hD};
            7'b0000110: r = {1'b1, 4'hE};
            7'b0001110: r = {1'b1, 4'hF};
`endif
            default:    r = 5'b0_0000;
        endcase
        return r;
    endfunction

    // A select is legal only when exactly one anode line is pulled low.
    assign sel_low   = ~bus.digit;
    assign sel_valid = (sel_low != 4'b0000) && ((sel_low & (sel_low - 4'd1)) == 4'b0000);
    assign same      = ({bus.digit, bus.seg} == sample_reg);

    // The accepted pattern is the one held in the sample register; a nonzero
    // count guarantees it carried a legal select.
    assign accept   = (cnt_reg == CNT_MAX) && !captured_reg;
    assign acc_pos  = ~sample_reg[10:7];
    assign acc_seg  = sample_reg[6:0];
    assign dec      = decode(acc_seg);
    assign is_blank = (acc_seg == SEG_OFF);
    assign capture  = accept && (is_blank || dec[4]);

    assign timeout_hit = !accept && (to_cnt_reg == TO_LAST);
    assign seen_set    = seen_reg | (capture ? acc_pos : 4'b0000);

    always_comb begin
        cnt_next         = cnt_reg;
        captured_next    = captured_reg;
        to_cnt_next      = to_cnt_reg;
        seen_next        = seen_set;
        stale_next       = stale_reg;
        err_next         = 1'b0;
        frame_valid_next = 1'b0;

        if (!sel_valid || !same) begin
            cnt_next      = '0;
            captured_next = 1'b0;
        end else begin
            if (cnt_reg != CNT_MAX)
                cnt_next = cnt_reg + 1'b1;
            if (accept)
                captured_next = 1'b1;
        end

        if (accept) begin
            to_cnt_next = '0;
            stale_next  = 1'b0;
            err_next    = !is_blank && !dec[4];
        end else if (to_cnt_reg != TO_MAX) begin
            to_cnt_next = to_cnt_reg + 1'b1;
        end

        if (timeout_hit) begin
            stale_next = 1'b1;
            seen_next  = 4'b0000;
        end else if (capture && (seen_set == 4'b1111)) begin
            frame_valid_next = 1'b1;
            seen_next        = 4'b0000;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sample_reg      <= '0;
            cnt_reg         <= '0;
            captured_reg    <= 1'b0;
            to_cnt_reg      <= '0;
            seen_reg        <= 4'b0000;
            stale_reg       <= 1'b0;
            err_reg         <= 1'b0;
            frame_valid_reg <= 1'b0;
        end else begin
            sample_reg      <= {bus.digit, bus.seg};
            cnt_reg         <= cnt_next;
            captured_reg    <= captured_next;
            to_cnt_reg      <= to_cnt_next;
            seen_reg        <= seen_next;
            stale_reg       <= stale_next;
            err_reg         <= err_next;
            frame_valid_reg <= frame_valid_next;
        end
    end

    // Per-position value and blank flag, written only by a capture at that position.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_pos
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    digit_reg[gi] <= 4'h0;
                    blank_reg[gi] <= 1'b1;
                end else if (capture && acc_pos[gi]) begin
                    blank_reg[gi] <= is_blank;
                    if (!is_blank)
                        digit_reg[gi] <= dec[3:0];
                end
            end
            assign bus.digits[4*gi +: 4] = digit_reg[gi];
        end
    endgenerate

    assign bus.blank       = blank_reg;
    assign bus.frame_valid = frame_valid_reg;
    assign bus.err         = err_reg;
    assign bus.stale       = stale_reg;

endmodule

// File: tb/tb_sevenseg_scan_decoder.sv
// Bench for sevenseg_scan_decoder: directed scans plus randomized dwells
// checked against a dwell-level reference model.
module tb_sevenseg_scan_decoder;

    localparam int S = 4;
    localparam int T = 1024;
`ifdef HEX_DECODE_EN
    localparam int NCODES = 16;
`else
    localparam int NCODES = 10;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    sevenseg_scan_decoder_if bus();

    sevenseg_scan_decoder #(.STABLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    int fv_seen  = 0;
    int err_seen = 0;

    // Count pulse-cycles of the status strobes away from the active edge.
    always @(negedge clk) begin
        if (bus.frame_valid === 1'b1) fv_seen <= fv_seen + 1;
        if (bus.err === 1'b1)         err_seen <= err_seen + 1;
    end

    logic [6:0] codes [16];
    logic [3:0] m_dig [4];
    logic [3:0] m_blank;
    logic [3:0] m_seen;
    logic       m_stale;
    int         m_fv;
    int         m_err;

    function automatic int lookup(input logic [6:0] s);
        for (int i = 0; i < NCODES; i++)
            if (codes[i] == s) return i;
        return -1;
    endfunction

    function automatic int sel_pos(input logic [3:0] d);
        int n = 0;
        int p = -1;
        for (int i = 0; i < 4; i++)
            if (d[i] == 1'b0) begin n++; p = i; end
        return (n == 1) ? p : -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_dig[i] = 4'h0;
        m_blank = 4'hF;
        m_seen  = 4'h0;
        m_stale = 1'b0;
    endtask

    // One held pattern: accepted iff the select is legal and it lasted S samples.
    task automatic model_dwell(input logic [3:0] d, input logic [6:0] s, input int hold);
        int p;
        int v;
        p = sel_pos(d);
        if (p < 0 || hold < S) return;
        m_stale = 1'b0;
        v = lookup(s);
        if (s == 7'h7F) begin
            m_blank[p] = 1'b1;
            m_seen[p]  = 1'b1;
        end else if (v >= 0) begin
            m_dig[p]   = v[3:0];
            m_blank[p] = 1'b0;
            m_seen[p]  = 1'b1;
        end else begin
            m_err++;
            return;
        end
        if (m_seen == 4'hF) begin
            m_fv++;
            m_seen = 4'h0;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".digits"}, 32'(bus.digits), 32'({m_dig[3], m_dig[2], m_dig[1], m_dig[0]}));
        check({tag, ".blank"}, 32'(bus.blank), 32'(m_blank));
        check({tag, ".frames"}, 32'(fv_seen), 32'(m_fv));
        check({tag, ".errs"}, 32'(err_seen), 32'(m_err));
        check({tag, ".stale"}, 32'(bus.stale), 32'(m_stale));
        $display("txn %s digits=%h blank=%b frames=%0d errs=%0d stale=%b",
                 tag, bus.digits, bus.blank, fv_seen, err_seen, bus.stale);
    endtask

    task automatic dwell(input logic [3:0] d, input logic [6:0] s, input int hold);
        bus.digit = d;
        bus.seg   = s;
        repeat (hold) begin @(posedge clk); #1; end
        model_dwell(d, s, hold);
    endtask

    task automatic gap(input int n);
        bus.digit = 4'b1111;
        bus.seg   = 7'h7F;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        codes[0]  = 7'b1000000; codes[1]  = 7'b1111001; codes[2]  = 7'b0100100;
        codes[3]  = 7'b0110000; codes[4]  = 7'b0011001; codes[5]  = 7'b0010010;
        codes[6]  = 7'b0000010; codes[7]  = 7'b1111000; codes[8]  = 7'b0000000;
        codes[9]  = 7'b0010000; codes[10] = 7'b0001000; codes[11] = 7'b0000011;
        codes[12] = 7'b1000110; codes[13] = 7'b0100001; codes[14] = 7'b0000110;
        codes[15] = 7'b0001110;
        m_fv = 0;
        m_err = 0;
        model_reset();

        bus.digit = 4'b1111;
        bus.seg   = 7'h7F;
        reset     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst.digits", 32'(bus.digits), 32'h0);
        check("rst.blank", 32'(bus.blank), 32'hF);
        check("rst.fv", 32'(bus.frame_valid), 32'h0);
        check("rst.err", 32'(bus.err), 32'h0);
        check("rst.stale", 32'(bus.stale), 32'h0);
        reset = 1'b1;
        gap(2);

        // "1234" scanned back to back
        dwell(4'b1110, 7'b1111001, 8);
        dwell(4'b1101, 7'b0100100, 8);
        dwell(4'b1011, 7'b0110000, 8);
        dwell(4'b0111, 7'b0011001, 8);
        gap(2);
        check("scan1234.value", 32'(bus.digits), 32'h4321);
        check("scan1234.pulses", 32'(fv_seen), 32'd1);
        check_all("scan1234");

        // dwell length boundary around S
        dwell(4'b1110, 7'b1000000, 2);     gap(2); check_all("hold2");
        dwell(4'b1110, 7'b1000000, S - 1); gap(2); check_all("hold3");
        dwell(4'b1110, 7'b1000000, S);     gap(2); check_all("hold4");

        // two anodes low never accepts, then a clean "7" on position 0
        dwell(4'b1100, 7'b1111000, 20);    gap(2); check_all("dual_sel");
        dwell(4'b1100, 7'b1111000, 20);
        dwell(4'b1110, 7'b1111000, S);     gap(2); check_all("seven");
        check("seven.nibble", 32'(bus.digits[3:0]), 32'h7);

        // undecodable pattern on position 2, then the hex 'A' glyph
        dwell(4'b1011, 7'b0110110, 6);     gap(2); check_all("bad_pos2");
        dwell(4'b1011, 7'b0001000, 6);     gap(2); check_all("hex_a");

        // timeout: still fresh at 1000 idle cycles, stale after the limit
        gap(1000);
        check("stale_early", 32'(bus.stale), 32'h0);
        gap(30);
        m_stale = 1'b1;
        m_seen  = 4'h0;
        check_all("timeout");
        dwell(4'b1101, 7'b0100100, 5);     gap(2); check_all("after_stale1");
        dwell(4'b1011, 7'b0110000, 5);
        dwell(4'b0111, 7'b0011001, 5);     gap(2); check_all("after_stale3");
        dwell(4'b1110, 7'b1111001, 5);     gap(2); check_all("after_stale4");

        // asynchronous reset in the middle of a frame
        dwell(4'b1110, 7'b0010010, 5);     gap(2); check_all("pre_reset");
        reset = 1'b0;
        #1;
        check("arst.digits", 32'(bus.digits), 32'h0);
        check("arst.blank", 32'(bus.blank), 32'hF);
        check("arst.fv", 32'(bus.frame_valid), 32'h0);
        check("arst.err", 32'(bus.err), 32'h0);
        check("arst.stale", 32'(bus.stale), 32'h0);
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;
        gap(2);
        dwell(4'b1101, 7'b0000010, 5);
        dwell(4'b1011, 7'b1111111, 5);
        dwell(4'b0111, 7'b0000000, 5);     gap(2); check_all("post_reset3");
        dwell(4'b1110, 7'b0010000, 5);     gap(2); check_all("post_reset4");

        // randomized dwells
        for (int n = 0; n < 50; n++) begin
            logic [3:0] d;
            logic [6:0] s;
            int r;
            int hold;
            r = $urandom_range(0, 3);
            d = ($urandom_range(0, 7) == 0) ? 4'($urandom) : ~(4'b0001 << r);
            r = $urandom_range(0, 9);
            if (r <= 5)      s = codes[$urandom_range(0, 9)];
            else if (r == 6) s = codes[$urandom_range(10, 15)];
            else if (r == 7) s = 7'h7F;
            else             s = 7'($urandom);
            hold = $urandom_range(1, 8);
            dwell(d, s, hold);
            gap(2);
            check_all($sformatf("rand%0d d=%b s=%b h=%0d", n, d, s, hold));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
